mmio_console: RTL and testbench

//  Memory-mapped console/stop device on the core data bus; parametrised successor of the print/stop peripheral.

---
 rtl/mmio_console_pkg.sv | 25 ++
 rtl/mmio_console_sync_fifo.sv | 73 +++++++
 rtl/mmio_console.sv | 162 ++++++++++++++++
 tb/tb_mmio_console.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_console_pkg.sv
// Shared definitions for the memory-mapped console/stop device.
// Contents:
//   - word offsets of the four registers in the 16-byte window
//   - data_mode encodings of the core data bus
//   - FSM state encodings (these also appear in STATUS[3:2])
package mmio_console_pkg;

  // Register word offsets (data_address[3:2])
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_STOP   = 2'd2;
  localparam logic [1:0] OFF_EXIT   = 2'd3;

  // data_mode encodings; the device only ever looks at byte lane 0
  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_WORD = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // FSM states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Single-clock FIFO used as the console TX buffer.
// Ports:
//   clk, reset      core clock, synchronous active-high reset (empties FIFO)
//   push, push_data write request and data; ignored when full unless pop
//                   happens in the same cycle
//   pop, pop_data   read request and head-of-FIFO data (combinational)
//   full, empty     occupancy flags
//   count           number of entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console/stop device on the shared core data bus.
// Software writes bytes to TXDATA; they are buffered and drained to a
// valid/ready byte stream. Writing STOP records an exit code and raises
// halt once the buffer has fully drained.
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   data_address      byte address from the core
//   data_bus          shared bidirectional bus, driven only on a read hit
//   data_cs, data_rw  bus cycle valid, 1 = write / 0 = read
//   data_mode         access size (unused: only byte lane 0 matters)
//   out_data          head-of-FIFO byte (0 when out_valid is low)
//   out_valid         out_data valid
//   out_ready         sink accepts
//   halt              stop request
//   exit_code         code written with STOP
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] ADDRESS   = 32'hffffff00,
  parameter int          DEPTH     = 16,
  parameter int          DRAIN_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  inout  wire  [31:0] data_bus,
  input  logic        data_cs,
  input  logic        data_rw,
  input  logic [1:0]  data_mode,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halt,
  output logic [7:0]  exit_code
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DRAIN_DIV - 1);

  logic             hit;
  logic [1:0]       offset;
  logic             wr_en;
  logic             rd_en;
  logic             push_req;
  logic             stop_wr;
  logic             status_wr;
  logic             handshake;
  logic [31:0]      rd_data;
  logic [8:0]       count_ext;
  logic             unused_bits;

  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic [1:0]       state_q, state_d;
  logic             halt_q, halt_d;
  logic [7:0]       exit_code_q, exit_code_d;
  logic             overflow_q, overflow_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Address decode: 16-byte window, addr[1:0] ignored.
  assign hit       = data_cs & (data_address[31:4] == ADDRESS[31:4]);
  assign offset    = data_address[3:2];
  assign wr_en     = hit & data_rw;
  assign rd_en     = hit & ~data_rw;
  assign push_req  = wr_en & (offset == OFF_TXDATA) & (state_q == ST_RUN);
  assign stop_wr   = wr_en & (offset == OFF_STOP);
  assign status_wr = wr_en & (offset == OFF_STATUS);

  // The output is held off while the inter-handshake spacing counter runs.
  assign out_valid = ~fifo_empty & (div_cnt_q == '0);
  assign out_data  = out_valid ? fifo_head : 8'h00;
  assign handshake = out_valid & out_ready;

  assign halt      = halt_q;
  assign exit_code = exit_code_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (data_bus[7:0]),
    .pop       (handshake),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // STATUS reports the low 8 bits of the count whatever DEPTH is.
  assign count_ext = 9'(fifo_count);

  always_comb begin
    rd_data = 32'h0;
    case (offset)
      OFF_STATUS: rd_data = {16'h0, count_ext[7:0], 4'h0, state_q, overflow_q, fifo_full};
      OFF_EXIT:   rd_data = {24'h0, exit_code_q};
      default:    rd_data = 32'h0;
    endcase
  end

  assign data_bus = rd_en ? rd_data : 32'bz;

  // Size and upper write lanes carry no meaning for this device.
  assign unused_bits = ^{data_mode, data_address[1:0], data_bus[31:8], count_ext[8]};

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    exit_code_d = exit_code_q;
    overflow_d  = overflow_q;
    div_cnt_d   = div_cnt_q;

    if (handshake)              div_cnt_d = DIV_RELOAD;
    else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - DIV_W'(1);

    // A push into a full FIFO is only lost when nothing leaves that cycle.
    if (push_req & fifo_full & ~handshake) overflow_d = 1'b1;
    else if (status_wr)                    overflow_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (stop_wr) begin
          state_d     = ST_DRAIN;
          exit_code_d = data_bus[7:0];
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      halt_q      <= 1'b0;
      exit_code_q <= 8'h00;
      overflow_q  <= 1'b0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
      overflow_q  <= overflow_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: one instance with DEPTH=8, DRAIN_DIV=1
// and one with DEPTH=16, DRAIN_DIV=4 (the latter with pull-ups on its bus
// so an undriven bus reads as all ones).
module tb_mmio_console;

  localparam logic [31:0] BASE = 32'hffffff00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance 1
  logic [31:0] addr1;
  logic        cs1, rw1, drv1, ready1;
  logic [1:0]  mode1;
  logic [31:0] wdat1;
  wire  [31:0] bus1;
  logic [7:0]  odata1, exit1;
  logic        ovalid1, halt1;
  assign bus1 = drv1 ? wdat1 : 32'bz;

  // Instance 4
  logic [31:0] addr4;
  logic        cs4, rw4, drv4, ready4;
  logic [1:0]  mode4;
  logic [31:0] wdat4;
  wire  [31:0] bus4;
  logic [7:0]  odata4, exit4;
  logic        ovalid4, halt4;
  assign bus4 = drv4 ? wdat4 : 32'bz;
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (bus4[g]);
  end

  mmio_console #(.ADDRESS(BASE), .DEPTH(8), .DRAIN_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .data_address(addr1), .data_bus(bus1),
    .data_cs(cs1), .data_rw(rw1), .data_mode(mode1), .out_data(odata1),
    .out_valid(ovalid1), .out_ready(ready1), .halt(halt1), .exit_code(exit1));

  mmio_console #(.ADDRESS(BASE), .DEPTH(16), .DRAIN_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .data_address(addr4), .data_bus(bus4),
    .data_cs(cs4), .data_rw(rw4), .data_mode(mode4), .out_data(odata4),
    .out_valid(ovalid4), .out_ready(ready4), .halt(halt4), .exit_code(exit4));

  // All tasks are entered just after a falling edge and return just after one.
  task automatic bus_write(input bit sel4, input logic [1:0] off, input logic [7:0] d);
    if (sel4) begin
      addr4 = BASE | {28'h0, off, 2'b00}; cs4 = 1; rw4 = 1; drv4 = 1; mode4 = 2'd2;
      wdat4 = {24'h5A5A5A, d};
    end else begin
      addr1 = BASE | {28'h0, off, 2'b00}; cs1 = 1; rw1 = 1; drv1 = 1; mode1 = 2'd0;
      wdat1 = {24'hA5A5A5, d};
    end
    @(negedge clk);
    cs1 = 0; rw1 = 0; drv1 = 0; cs4 = 0; rw4 = 0; drv4 = 0;
  endtask

  task automatic bus_read(input bit sel4, input logic [31:0] a, output logic [31:0] v);
    if (sel4) begin
      addr4 = a; cs4 = 1; rw4 = 0; drv4 = 0; #1 v = bus4; cs4 = 0;
    end else begin
      addr1 = a; cs1 = 1; rw1 = 0; drv1 = 0; #1 v = bus1; cs1 = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    total_cnt++; if (ovalid1 !== 1'b0) $display("FAIL rst_valid: got %b want 0", ovalid1); else pass_cnt++;
    total_cnt++; if (odata1 !== 8'h00) $display("FAIL rst_data: got %h want 00", odata1); else pass_cnt++;
    total_cnt++; if (halt1 !== 1'b0 || exit1 !== 8'h00) $display("FAIL rst_halt_exit: got %b/%h want 0/00", halt1, exit1); else pass_cnt++;
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL rst_status: got %h want 00000000", v); else pass_cnt++;
  endtask

  task automatic test_basic_tx();
    logic [31:0] v;
    ready1 = 1;
    bus_write(0, 2'd0, 8'h48);
    total_cnt++; if (ovalid1 !== 1'b1 || odata1 !== 8'h48) $display("FAIL tx_first: got %b/%h want 1/48", ovalid1, odata1); else pass_cnt++;
    bus_write(0, 2'd0, 8'h69);
    total_cnt++; if (ovalid1 !== 1'b1 || odata1 !== 8'h69) $display("FAIL tx_second: got %b/%h want 1/69", ovalid1, odata1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ovalid1 !== 1'b0) $display("FAIL tx_idle: got %b want 0", ovalid1); else pass_cnt++;
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL tx_status: got %h want 00000000", v); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    ready1 = 0;
    for (int i = 0; i < 9; i++) bus_write(0, 2'd0, 8'h10 + 8'(i));
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0803) $display("FAIL ovf_status: got %h want 00000803", v); else pass_cnt++;
    ready1 = 1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (ovalid1 !== 1'b1 || odata1 !== 8'h10 + 8'(i))
        $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, ovalid1, odata1, 8'h10 + 8'(i));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (ovalid1 !== 1'b0) $display("FAIL ovf_dropped: got valid %b data %h want 0", ovalid1, odata1); else pass_cnt++;
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0002) $display("FAIL ovf_sticky: got %h want 00000002", v); else pass_cnt++;
    bus_write(0, 2'd1, 8'h00);
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL ovf_clear: got %h want 00000000", v); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    ready1 = 0;
    for (int i = 0; i < 8; i++) bus_write(0, 2'd0, 8'h20 + 8'(i));
    ready1 = 1;
    bus_write(0, 2'd0, 8'h28);
    ready1 = 0;
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0801) $display("FAIL fpp_status: got %h want 00000801", v); else pass_cnt++;
    ready1 = 1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (ovalid1 !== 1'b1 || odata1 !== 8'h21 + 8'(i))
        $display("FAIL fpp_drain%0d: got %b/%h want 1/%h", i, ovalid1, odata1, 8'h21 + 8'(i));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (ovalid1 !== 1'b0) $display("FAIL fpp_empty: got %b want 0", ovalid1); else pass_cnt++;
  endtask

  task automatic test_stop_drain();
    logic [31:0] v;
    ready1 = 0;
    for (int i = 0; i < 3; i++) bus_write(0, 2'd0, 8'h31 + 8'(i));
    bus_write(0, 2'd2, 8'h2A);
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0304) $display("FAIL stop_status: got %h want 00000304", v); else pass_cnt++;
    total_cnt++; if (halt1 !== 1'b0) $display("FAIL stop_nohalt: got %b want 0", halt1); else pass_cnt++;
    ready1 = 1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ovalid1 !== 1'b1 || odata1 !== 8'h31 + 8'(i) || halt1 !== 1'b0)
        $display("FAIL stop_drain%0d: got %b/%h halt %b want 1/%h halt 0", i, ovalid1, odata1, halt1, 8'h31 + 8'(i));
      else pass_cnt++;
      @(negedge clk);
    end
    // FIFO is empty this cycle; halt follows on the next one.
    total_cnt++; if (halt1 !== 1'b0 || ovalid1 !== 1'b0) $display("FAIL stop_empty: got halt %b valid %b want 0/0", halt1, ovalid1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (halt1 !== 1'b1) $display("FAIL stop_halt: got %b want 1", halt1); else pass_cnt++;
    bus_read(0, BASE | 32'hC, v);
    total_cnt++; if (v !== 32'h2A) $display("FAIL stop_exit: got %h want 0000002a", v); else pass_cnt++;
    bus_write(0, 2'd0, 8'h55);
    bus_write(0, 2'd2, 8'h77);
    total_cnt++; if (ovalid1 !== 1'b0) $display("FAIL halted_tx: got %b want 0", ovalid1); else pass_cnt++;
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0008) $display("FAIL halted_status: got %h want 00000008", v); else pass_cnt++;
    total_cnt++; if (exit1 !== 8'h2A) $display("FAIL halted_exit: got %h want 2a", exit1); else pass_cnt++;
  endtask

  task automatic test_stop_empty();
    logic [31:0] v;
    do_reset();
    bus_write(0, 2'd2, 8'h05);
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0004 || halt1 !== 1'b0) $display("FAIL se_drain: got %h halt %b want 00000004 halt 0", v, halt1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (halt1 !== 1'b1 || exit1 !== 8'h05) $display("FAIL se_halt: got %b/%h want 1/05", halt1, exit1); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] v;
    do_reset();
    ready1 = 0;
    for (int i = 0; i < 5; i++) bus_write(0, 2'd0, 8'h60 + 8'(i));
    bus_write(0, 2'd2, 8'h11);
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0504) $display("FAIL rmd_pre: got %h want 00000504", v); else pass_cnt++;
    reset = 1;
    @(negedge clk);
    reset = 0;
    total_cnt++; if (ovalid1 !== 1'b0 || halt1 !== 1'b0) $display("FAIL rmd_out: got valid %b halt %b want 0/0", ovalid1, halt1); else pass_cnt++;
    bus_read(0, BASE | 32'h4, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL rmd_status: got %h want 00000000", v); else pass_cnt++;
    total_cnt++; if (exit1 !== 8'h00) $display("FAIL rmd_exit: got %h want 00", exit1); else pass_cnt++;
  endtask

  task automatic test_drain_div();
    logic [31:0] v;
    int hs [$];
    logic [7:0] got [$];
    do_reset();
    ready4 = 0;
    for (int i = 0; i < 3; i++) bus_write(1, 2'd0, 8'hA1 + 8'(i));
    ready4 = 1;
    for (int i = 0; i < 20; i++) begin
      if (ovalid4 && ready4) begin hs.push_back(i); got.push_back(odata4); end
      @(negedge clk);
    end
    total_cnt++; if (hs.size() != 3) $display("FAIL div_count: got %0d handshakes want 3", hs.size()); else pass_cnt++;
    if (hs.size() == 3) begin
      total_cnt++; if (hs[0] != 0 || hs[1] != 4 || hs[2] != 8) $display("FAIL div_spacing: got %0d,%0d,%0d want 0,4,8", hs[0], hs[1], hs[2]); else pass_cnt++;
      total_cnt++; if (got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3) $display("FAIL div_data: got %h,%h,%h want a1,a2,a3", got[0], got[1], got[2]); else pass_cnt++;
    end
    bus_read(1, 32'hFFFFFE04, v);
    total_cnt++; if (v !== 32'hFFFFFFFF) $display("FAIL nohit_bus: got %h want ffffffff (undriven)", v); else pass_cnt++;
    bus_read(1, BASE | 32'hC, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL hit_bus4: got %h want 00000000", v); else pass_cnt++;
  endtask

  initial begin
    reset = 1;
    addr1 = 0; cs1 = 0; rw1 = 0; drv1 = 0; mode1 = 0; wdat1 = 0; ready1 = 0;
    addr4 = 0; cs4 = 0; rw4 = 0; drv4 = 0; mode4 = 0; wdat4 = 0; ready4 = 0;
    @(negedge clk);
    test_reset();
    test_basic_tx();
    test_overflow();
    test_full_push_pop();
    test_stop_drain();
    test_stop_empty();
    test_reset_mid_drain();
    test_drain_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
